// File: rtl/f2s_axi_burst_writer.sv
// Copies a block of BRAM words to HPS SDRAM over an AXI3 write port, split into INCR bursts
// that never cross a 4 KB boundary. One burst outstanding at a time.
module f2s_axi_burst_writer #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned AXI_ID    = 0,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned BRAM_AW   = 10
) (
  input  logic                clk,
  input  logic                reset,
  // job configuration / status
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [31:0]         cfg_len,
  input  logic                cfg_start,
  output logic                busy,
  output logic                done,
  output logic                err,
  // BRAM read port
  output logic [BRAM_AW-1:0]  bram_addr,
  output logic                bram_rd_en,
  input  logic [DATA_W-1:0]   bram_rdata,
  // AXI3 write address
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awlen,
  output logic [ID_W-1:0]     awid,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [2:0]          awprot,
  output logic [3:0]          awcache,
  output logic                awvalid,
  input  logic                awready,
  // AXI3 write data
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic [ID_W-1:0]     wid,
  output logic                wvalid,
  input  logic                wready,
  // AXI3 write response
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  input  logic                bvalid,
  output logic                bready
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BSH   = $clog2(BYTES);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StResp, StFin} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         beats_q;
  logic [4:0]          nb_q;
  logic [4:0]          rd_left_q;
  logic [4:0]          wr_left_q;
  logic [1:0]          cnt_q;
  logic                inflight_q;
  logic [DATA_W-1:0]   buf0_q;
  logic [DATA_W-1:0]   buf1_q;
  logic [BRAM_AW-1:0]  bram_addr_q;

  logic                pop;
  logic [2:0]          occ;
  logic                rd_issue;
  logic [31:0]         start_beats;
  logic [4:0]          start_nb;
  logic [ADDR_W-1:0]   next_addr;
  logic [31:0]         next_beats;
  logic [4:0]          next_nb;
  logic                unused_bid;

  // Beats that fit before the next 4 KB boundary, capped by MAX_BURST and the job remainder.
  function automatic logic [4:0] calc_nb(input logic [11:0] a, input logic [31:0] beats);
    logic [12:0] room;
    logic [31:0] n;
    room = (13'd4096 - {1'b0, a}) >> BSH;
    n    = 32'(MAX_BURST);
    if (beats < n) n = beats;
    if ({19'd0, room} < n) n = {19'd0, room};
    return n[4:0];
  endfunction

  assign start_beats = cfg_len >> BSH;
  assign start_nb    = calc_nb(cfg_addr[11:0], start_beats);
  assign next_addr   = addr_q + (ADDR_W'(nb_q) << BSH);
  assign next_beats  = beats_q - 32'(nb_q);
  assign next_nb     = calc_nb(next_addr[11:0], next_beats);

  assign wvalid = (cnt_q != 2'd0);
  assign wlast  = wvalid && (wr_left_q == 5'd1);
  assign wdata  = buf0_q;
  assign pop    = wvalid && wready;

  // Occupancy after this cycle's pop, counting the read whose data lands this cycle.
  assign occ        = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign rd_issue   = (state_q == StData) && (rd_left_q != 5'd0) && (occ < 3'd2);
  assign bram_rd_en = rd_issue;
  assign bram_addr  = bram_addr_q;

  assign awid    = ID_W'(AXI_ID);
  assign wid     = ID_W'(AXI_ID);
  assign awsize  = 3'(BSH);
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awprot  = 3'b000;
  assign awcache = 4'b0011;
  assign wstrb   = '1;

  assign unused_bid = ^bid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      beats_q     <= '0;
      nb_q        <= '0;
      rd_left_q   <= '0;
      wr_left_q   <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      bram_addr_q <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      awvalid     <= 1'b0;
      awaddr      <= '0;
      awlen       <= '0;
      bready      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cfg_start) begin
            addr_q      <= cfg_addr;
            beats_q     <= start_beats;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
            cnt_q       <= '0;
            inflight_q  <= 1'b0;
            bram_addr_q <= '0;
            if (start_beats == 32'd0) begin
              state_q <= StFin;
            end else begin
              state_q <= StAddr;
              awvalid <= 1'b1;
              awaddr  <= cfg_addr;
              awlen   <= 4'(start_nb - 5'd1);
              nb_q    <= start_nb;
            end
          end
        end
        StAddr: begin
          if (awready) begin
            awvalid   <= 1'b0;
            rd_left_q <= nb_q;
            wr_left_q <= nb_q;
            state_q   <= StData;
          end
        end
        StData: begin
          inflight_q <= rd_issue;
          cnt_q      <= occ[1:0];
          if (rd_issue) begin
            rd_left_q   <= rd_left_q - 5'd1;
            bram_addr_q <= bram_addr_q + 1'b1;
          end
          // Two-entry shift buffer: buf0 is always the head presented on wdata.
          if (pop) begin
            buf0_q <= (cnt_q == 2'd2) ? buf1_q : bram_rdata;
            if ((cnt_q == 2'd2) && inflight_q) buf1_q <= bram_rdata;
            wr_left_q <= wr_left_q - 5'd1;
            if (wr_left_q == 5'd1) begin
              state_q <= StResp;
              bready  <= 1'b1;
            end
          end else if (inflight_q) begin
            if (cnt_q == 2'd0) buf0_q <= bram_rdata;
            else               buf1_q <= bram_rdata;
          end
        end
        StResp: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) begin
              err     <= 1'b1;
              state_q <= StFin;
            end else begin
              addr_q  <= next_addr;
              beats_q <= next_beats;
              if (next_beats == 32'd0) begin
                state_q <= StFin;
              end else begin
                state_q <= StAddr;
                awvalid <= 1'b1;
                awaddr  <= next_addr;
                awlen   <= 4'(next_nb - 5'd1);
                nb_q    <= next_nb;
              end
            end
          end
        end
        StFin: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_f2s_axi_burst_writer.sv
// Scoreboard bench for f2s_axi_burst_writer: directed jobs push expected AW/W traffic, a
// negedge monitor pops and compares, a small AXI slave and BRAM model drive the inputs.
module tb_f2s_axi_burst_writer;

  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     cfg_addr;
  logic [31:0]     cfg_len;
  logic            cfg_start;
  logic            busy, done, err;
  logic [9:0]      bram_addr;
  logic            bram_rd_en;
  logic [DW-1:0]   bram_rdata = '0;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [7:0]      awid;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [2:0]      awprot;
  logic [3:0]      awcache;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic [7:0]      wid;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic [7:0]      bid;
  logic            bvalid;
  logic            bready;

  always #5 clk = ~clk;

  f2s_axi_burst_writer #(
    .DATA_W(256), .ADDR_W(32), .ID_W(8), .AXI_ID(0), .MAX_BURST(16), .BRAM_AW(10)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_start(cfg_start),
    .busy(busy), .done(done), .err(err),
    .bram_addr(bram_addr), .bram_rd_en(bram_rd_en), .bram_rdata(bram_rdata),
    .awaddr(awaddr), .awlen(awlen), .awid(awid), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awprot(awprot), .awcache(awcache), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [3:0] len;} aw_t;
  typedef struct {logic [255:0] data; logic last;} w_t;
  aw_t exp_aw[$];
  w_t  exp_w[$];

  function automatic logic [255:0] word(input int i);
    return {8{32'hB000_0000 + 32'(i)}};
  endfunction

  task automatic push_burst(input logic [31:0] a, input int beats, input int first);
    aw_t t;
    w_t  w;
    t.addr = a;
    t.len  = 4'(beats - 1);
    exp_aw.push_back(t);
    for (int k = 0; k < beats; k++) begin
      w.data = word(first + k);
      w.last = (k == beats - 1);
      exp_w.push_back(w);
    end
  endtask

  // BRAM model: one-cycle registered read
  always @(posedge clk) if (bram_rd_en) bram_rdata <= word(int'(bram_addr));

  // Monitor
  logic aw_open  = 1'b0;
  int   beat_cnt = 0;
  aw_t  aw_got;
  always @(negedge clk) begin
    if (!reset) begin
      if (wvalid) begin
        chk("w_after_aw", aw_open, 1'b1);
        if (exp_w.size() == 0) begin
          chk("w_unexpected", wvalid, 1'b0);
        end else begin
          chk("wdata", wdata, exp_w[0].data);
          chk("wlast", wlast, exp_w[0].last);
          if (wready) begin
            if (exp_w[0].last) aw_open = 1'b0;
            void'(exp_w.pop_front());
            beat_cnt++;
          end
        end
      end
      if (awvalid && awready) begin
        chk("aw_single_outstanding", aw_open, 1'b0);
        if (exp_aw.size() == 0) begin
          chk("aw_unexpected", awvalid, 1'b0);
        end else begin
          aw_got = exp_aw.pop_front();
          chk("awaddr", awaddr, aw_got.addr);
          chk("awlen", awlen, aw_got.len);
        end
        aw_open = 1'b1;
      end
    end else begin
      aw_open = 1'b0;
    end
  end

  // AXI slave model
  int   burst_cnt = 0;
  int   err_burst = -1;
  bit   stall     = 1'b0;
  logic wl, bh;
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    bid     = 8'd0;
    forever begin
      @(negedge clk);
      wl = wvalid && wready && wlast;
      bh = bvalid && bready;
      @(posedge clk);
      #1;
      if (reset) begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
      end else begin
        awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bh) bvalid = 1'b0;
        if (wl) begin
          bvalid = 1'b1;
          bresp  = (burst_cnt == err_burst) ? 2'b10 : 2'b00;
          burst_cnt++;
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] a, input logic [31:0] l);
    @(posedge clk);
    #1;
    cfg_addr  = a;
    cfg_len   = l;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic end_checks(input string tag, input logic exp_err);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_aw_left"}, 32'(exp_aw.size()), 32'd0);
    chk({tag, "_w_left"}, 32'(exp_w.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b0;
  initial begin
    reset     = 1'b1;
    cfg_addr  = '0;
    cfg_len   = '0;
    cfg_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_en", bram_rd_en, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_bram_addr", bram_addr, 10'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_awlen", awlen, 4'd0);
    chk("const_awsize", awsize, 3'd5);
    chk("const_awburst", awburst, 2'b01);
    chk("const_awlock", awlock, 2'b00);
    chk("const_awprot", awprot, 3'b000);
    chk("const_awcache", awcache, 4'b0011);
    chk("const_wstrb", wstrb, {32{1'b1}});
    chk("const_ids", {awid, wid}, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // T1: single one-beat burst
    push_burst(32'h0, 1, 0);
    start_job(32'h0, 32'd32);
    wait_done(100, "t1_done");
    end_checks("t1", 1'b0);

    // T2: 20 beats at 0x1000 -> 16 + 4, with an ignored start while busy
    push_burst(32'h1000, 16, 0);
    push_burst(32'h1200, 4, 16);
    start_job(32'h1000, 32'd640);
    repeat (4) @(posedge clk);
    #1;
    cfg_addr  = 32'h2000;
    cfg_len   = 32'd32;
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("t2_busy_after_ignored_start", busy, 1'b1);
    chk("t2_done_after_ignored_start", done, 1'b0);
    wait_done(300, "t2_done");
    end_checks("t2", 1'b0);

    // T3: 4 KB split
    push_burst(32'h0FC0, 2, 0);
    push_burst(32'h1000, 2, 2);
    start_job(32'h0FC0, 32'd128);
    wait_done(200, "t3_done");
    end_checks("t3", 1'b0);

    // T4: T2 under random backpressure
    stall = 1'b1;
    b0    = beat_cnt;
    push_burst(32'h1000, 16, 0);
    push_burst(32'h1200, 4, 16);
    start_job(32'h1000, 32'd640);
    wait_done(1000, "t4_done");
    chk("t4_beats", 32'(beat_cnt - b0), 32'd20);
    end_checks("t4", 1'b0);
    stall = 1'b0;

    // T5: SLVERR on first burst aborts the job
    err_burst = burst_cnt;
    push_burst(32'h1000, 16, 0);
    start_job(32'h1000, 32'd640);
    wait_done(300, "t5_done");
    err_burst = -1;
    end_checks("t5", 1'b1);
    repeat (10) @(negedge clk);
    push_burst(32'h40, 1, 0);
    start_job(32'h40, 32'd32);
    @(negedge clk);
    chk("t5_err_cleared", err, 1'b0);
    wait_done(100, "t5b_done");
    end_checks("t5b", 1'b0);

    // T6: zero-length job
    start_job(32'h0, 32'd0);
    @(posedge clk);
    #1;
    chk("t6_done_fast", done, 1'b1);
    end_checks("t6", 1'b0);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
